// File: rtl/div_pkg.sv
// Shared types and op-decode helpers for the iterative integer divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic is_signed(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem(div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Final remainder restore and signed negation of quotient/remainder for the
// non-restoring divider core.
module div_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    input  logic             neg_q,
    input  logic             neg_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] r_abs;

    // A negative final partial remainder lies in [-d, 0); one add brings it to [0, d).
    always_comb begin
        r_abs = rem[WIDTH] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0];
        q     = neg_q ? (WIDTH'(0) - quo) : quo;
        r     = neg_r ? (WIDTH'(0) - r_abs) : r_abs;
    end

endmodule

// File: rtl/div_iter.sv
// Iterative RV32M/RV64M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional last-result reuse is enabled by defining DIV_RESULT_REUSE_EN.
module div_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    import div_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_CALC = 2'(CALC);
    localparam logic [1:0] S_FIX  = 2'(FIX);
    localparam logic [1:0] S_DONE = 2'(DONE);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [1:0]       state_q, state_d;
    logic             accept, fast;
    logic             req_signed, req_rem, a_neg, b_neg, div0, ovf, hit;
    logic [WIDTH-1:0] a_abs, b_abs, fast_result, hit_result;
    logic [WIDTH:0]   rem_q, rem_sh, rem_nx;
    logic [WIDTH-1:0] quo_q, quo_nx, dvs_q, fix_q, fix_r;
    logic [CNT_W-1:0] cnt_q;
    logic             a_sign_q, b_sign_q, rem_op_q;
    logic [TAG_W-1:0] tag_q;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid & in_ready & ~flush;

    // Request decode: magnitudes and the RISC-V special cases.
    always_comb begin
        req_signed = is_signed(div_op_e'(in_op));
        req_rem    = is_rem(div_op_e'(in_op));
        a_neg      = req_signed & in_a[WIDTH-1];
        b_neg      = req_signed & in_b[WIDTH-1];
        a_abs      = a_neg ? (WIDTH'(0) - in_a) : in_a;
        b_abs      = b_neg ? (WIDTH'(0) - in_b) : in_b;
        div0       = (in_b == '0);
        ovf        = req_signed & (in_a == MIN_NEG) & (in_b == ALL_ONES);
    end

    // Single-cycle results bypass the iteration entirely.
    always_comb begin
        fast        = div0 | ovf | hit;
        fast_result = hit_result;
        if (div0)
            fast_result = req_rem ? in_a : ALL_ONES;
        else if (ovf)
            fast_result = req_rem ? '0 : in_a;
    end

`ifdef DIV_RESULT_REUSE_EN
    logic             reuse_vld_q, reuse_sgn_q, sgn_q;
    logic [WIDTH-1:0] reuse_a_q, reuse_b_q, reuse_qt_q, reuse_rm_q;
    logic [WIDTH-1:0] a_raw_q, b_raw_q;

    assign hit        = reuse_vld_q & (in_a == reuse_a_q) & (in_b == reuse_b_q)
                        & (req_signed == reuse_sgn_q);
    assign hit_result = req_rem ? reuse_rm_q : reuse_qt_q;

    // Last completed iterative result, keyed on raw operands and signedness.
    always_ff @(posedge clk) begin
        if (reset) begin
            reuse_vld_q <= 1'b0;
            reuse_sgn_q <= 1'b0;
            reuse_a_q   <= '0;
            reuse_b_q   <= '0;
            reuse_qt_q  <= '0;
            reuse_rm_q  <= '0;
            a_raw_q     <= '0;
            b_raw_q     <= '0;
            sgn_q       <= 1'b0;
        end else begin
            if (accept) begin
                a_raw_q <= in_a;
                b_raw_q <= in_b;
                sgn_q   <= req_signed;
            end
            if (flush) begin
                reuse_vld_q <= 1'b0;
            end else if (state_q == S_FIX) begin
                reuse_vld_q <= 1'b1;
                reuse_sgn_q <= sgn_q;
                reuse_a_q   <= a_raw_q;
                reuse_b_q   <= b_raw_q;
                reuse_qt_q  <= fix_q;
                reuse_rm_q  <= fix_r;
            end
        end
    end
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    // Next-state logic; flush overrides everything except reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: begin
                if (accept)
                    state_d = fast ? S_DONE : S_CALC;
                else if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Non-restoring step: subtract while the partial remainder is non-negative.
    always_comb begin
        rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_nx = rem_q[WIDTH] ? (rem_sh + {1'b0, dvs_q}) : (rem_sh - {1'b0, dvs_q});
        quo_nx = {quo_q[WIDTH-2:0], ~rem_nx[WIDTH]};
    end

    div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .rem   (rem_q),
        .quo   (quo_q),
        .dvs   (dvs_q),
        .neg_q (a_sign_q ^ b_sign_q),
        .neg_r (a_sign_q),
        .q     (fix_q),
        .r     (fix_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            rem_op_q   <= 1'b0;
            tag_q      <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (accept) begin
            rem_q    <= '0;
            quo_q    <= a_abs;
            dvs_q    <= b_abs;
            cnt_q    <= '0;
            a_sign_q <= a_neg;
            b_sign_q <= b_neg;
            rem_op_q <= req_rem;
            tag_q    <= in_tag;
            if (fast) begin
                out_result <= fast_result;
                out_tag    <= in_tag;
            end
        end else if (state_q == S_CALC) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if ((state_q == S_FIX) && !flush) begin
            out_result <= rem_op_q ? fix_r : fix_q;
            out_tag    <= tag_q;
        end
    end

endmodule
